clkdiv_ctrl: RTL

Programmable divide-by-N toggle controller. It sequences the divided output through start, run and clean stop, and accepts divide-ratio updates over a valid/ready handshake. Updates are applied only on a period boundary, so q never glitches. It sits between the config/control logic and any consumer of the slowed clock-enable (q) or of the per-toggle strobe (tick).

---
 rtl/clkdiv_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/clkdiv_ctrl.sv
// Programmable divide-by-N toggle controller with start/run/clean-stop
// sequencing and boundary-aligned ratio updates over a valid/ready port.
module clkdiv_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cur_div,
  output logic             busy,
  output logic             q,
  output logic             tick
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] pend_div;
  logic             pend_vld;
  logic             xfer, div_ok, wrap, kill, leave;

  assign cfg_ready = !pend_vld;
  assign busy      = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign div_ok    = xfer && (cfg_div != '0);
  assign wrap      = (state != IDLE) && (counter == cur_div - ONE);
  // kill: stop request while q is low, leave immediately without a toggle.
  // leave: the wrap that brings q low while stopping.
  assign kill      = (state == RUN) && !en && !q;
  assign leave     = !kill && wrap && ((state == DRAIN) || !en);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      counter  <= '0;
      q        <= 1'b0;
      tick     <= 1'b0;
      cfg_err  <= 1'b0;
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_div <= '0;
      pend_vld <= 1'b0;
    end else begin
      tick    <= 1'b0;
      cfg_err <= xfer && (cfg_div == '0);
      case (state)
        IDLE: begin
          counter <= '0;
          q       <= 1'b0;
          if (div_ok) cur_div <= cfg_div;
          if (en) state <= RUN;
        end
        default: begin
          if (kill) begin
            counter <= '0;
          end else if (wrap) begin
            counter <= '0;
            q       <= ~q;
            tick    <= 1'b1;
          end else begin
            counter <= counter + ONE;
          end

          if (kill || leave) begin
            // Entering IDLE: any outstanding ratio takes effect now.
            state    <= IDLE;
            pend_vld <= 1'b0;
            if (pend_vld)    cur_div <= pend_div;
            else if (div_ok) cur_div <= cfg_div;
          end else begin
            if ((state == RUN) && !en) state <= DRAIN;
            if (wrap && pend_vld) begin
              cur_div  <= pend_div;
              pend_vld <= 1'b0;
            end else if (div_ok) begin
              pend_div <= cfg_div;
              pend_vld <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
